// File: rtl/rename_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module      : rename_regfile_mp
// Description : Multi-ported architectural register file with per-register
//               rename locks. Commits from the ROB write data and release
//               locks owned by the committing entry; the decoder renames
//               registers to ROB entries and reads data/lock pairs with a
//               lock-aware same-cycle commit bypass. Flush drops all locks.
//               A registered count of locked registers is provided.
// Ports       : clk, rst (async, active-high), flush
//               cm_we/cm_name/cm_data/cm_entry : NUM_CM commit ports (0 oldest)
//               rn_we/rn_name/rn_entry         : rename request
//               rd_en/rd_name -> rd_lock/rd_data : NUM_RD combinational reads
//               locked_cnt                     : registered locked-reg count
// Revision    : 1.0 - initial release
// ============================================================================
module rename_regfile_mp #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int ROB_W  = 4,
    parameter int NUM_RD = 2,
    parameter int NUM_CM = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [NUM_CM-1:0]             cm_we,
    input  logic [NUM_CM*REG_W-1:0]       cm_name,
    input  logic [NUM_CM*DATA_W-1:0]      cm_data,
    input  logic [NUM_CM*ROB_W-1:0]       cm_entry,
    input  logic                          rn_we,
    input  logic [REG_W-1:0]              rn_name,
    input  logic [ROB_W-1:0]              rn_entry,
    input  logic [NUM_RD-1:0]             rd_en,
    input  logic [NUM_RD*REG_W-1:0]       rd_name,
    output logic [NUM_RD*(ROB_W+1)-1:0]   rd_lock,
    output logic [NUM_RD*DATA_W-1:0]      rd_data,
    output logic [REG_W:0]                locked_cnt
);

    localparam int REG_CNT = 2 ** REG_W;
    localparam int LOCK_W  = ROB_W + 1;
    localparam logic [LOCK_W-1:0] c_no_lock = {1'b1, {ROB_W{1'b0}}};

    logic [DATA_W-1:0] r_dat [REG_CNT];
    logic [LOCK_W-1:0] r_loc [REG_CNT];
    logic [REG_W:0]    r_locked_cnt;

    logic [DATA_W-1:0] w_dat_nxt [REG_CNT];
    logic [LOCK_W-1:0] w_loc_nxt [REG_CNT];
    logic [REG_W:0]    w_cnt_nxt;

    // ------------------------------------------------------------------
    // Next-state: commits in ascending port order so the highest index
    // wins the data write; a lock is released if any committing port on
    // that register carries the owning entry. Flush beats rename beats
    // commit release. r0 is pinned to zero / unlocked.
    // ------------------------------------------------------------------
    always_comb begin
        logic w_clr;
        w_cnt_nxt = '0;
        for (int r = 0; r < REG_CNT; r++) begin
            w_dat_nxt[r] = r_dat[r];
            w_clr        = 1'b0;
            for (int i = 0; i < NUM_CM; i++) begin
                if (cm_we[i] && (cm_name[i*REG_W +: REG_W] == REG_W'(r)) && (r != 0)) begin
                    w_dat_nxt[r] = cm_data[i*DATA_W +: DATA_W];
                    if (r_loc[r] == {1'b0, cm_entry[i*ROB_W +: ROB_W]}) begin
                        w_clr = 1'b1;
                    end
                end
            end
            if (r == 0 || flush) begin
                w_loc_nxt[r] = c_no_lock;
            end else if (rn_we && (rn_name == REG_W'(r))) begin
                w_loc_nxt[r] = {1'b0, rn_entry};
            end else if (w_clr) begin
                w_loc_nxt[r] = c_no_lock;
            end else begin
                w_loc_nxt[r] = r_loc[r];
            end
            w_cnt_nxt = w_cnt_nxt + {{REG_W{1'b0}}, ~w_loc_nxt[r][LOCK_W-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < REG_CNT; r++) begin
                r_dat[r] <= '0;
                r_loc[r] <= c_no_lock;
            end
            r_locked_cnt <= '0;
        end else begin
            for (int r = 0; r < REG_CNT; r++) begin
                r_dat[r] <= w_dat_nxt[r];
                r_loc[r] <= w_loc_nxt[r];
            end
            r_locked_cnt <= w_cnt_nxt;
        end
    end

    assign locked_cnt = r_locked_cnt;

    // ------------------------------------------------------------------
    // Reads: stored state plus same-cycle commit bypass. The bypassed
    // lock is dropped only when a committing port owns it; rename and
    // flush in the same cycle are deliberately not forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        logic [REG_W-1:0]  w_name;
        logic [LOCK_W-1:0] w_base;
        logic [DATA_W-1:0] w_data;
        logic              w_rclr;
        rd_lock = '0;
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            w_name = rd_name[p*REG_W +: REG_W];
            w_base = r_loc[w_name];
            w_data = r_dat[w_name];
            w_rclr = 1'b0;
            for (int i = 0; i < NUM_CM; i++) begin
                if (cm_we[i] && (cm_name[i*REG_W +: REG_W] == w_name) && (w_name != '0)) begin
                    w_data = cm_data[i*DATA_W +: DATA_W];
                    if (w_base == {1'b0, cm_entry[i*ROB_W +: ROB_W]}) begin
                        w_rclr = 1'b1;
                    end
                end
            end
            if (rd_en[p]) begin
                rd_lock[p*LOCK_W +: LOCK_W] = w_rclr ? c_no_lock : w_base;
                rd_data[p*DATA_W +: DATA_W] = w_data;
            end else begin
                rd_lock[p*LOCK_W +: LOCK_W] = c_no_lock;
                rd_data[p*DATA_W +: DATA_W] = '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/rename_regfile_mp.md
Name: rename_regfile_mp

Overview:
- Multi-ported architectural register file with per-register rename locks for the Tomasulo/ROB core.
- Successor to the single-commit, two-read register file. Adds a parametrised read-port count and commit width, a read bypass that is lock-aware, and a flush that clears all locks.
- Adds a registered count of locked registers, used by the decoder for stall heuristics.
- Sits between the decoder (rename/read) and the ROB (in-order commit).

Parameters:
- DATA_W, 32, register data width.
- REG_W, 5, register name width; REG_CNT = 2**REG_W.
- ROB_W, 4, ROB entry index width; LOCK_W = ROB_W+1.
- NUM_RD, 2, number of read ports.
- NUM_CM, 2, number of commit ports per cycle. Index 0 is the oldest.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, asynchronous, active-high.
- flush, input, 1, misprediction recovery: clear every lock.
- cm_we, input, NUM_CM, per-port commit valid.
- cm_name, input, NUM_CM*REG_W, commit destination register; port i occupies bits [i*REG_W +: REG_W].
- cm_data, input, NUM_CM*DATA_W, commit value.
- cm_entry, input, NUM_CM*ROB_W, ROB entry being committed.
- rn_we, input, 1, decoder rename valid.
- rn_name, input, REG_W, register being renamed.
- rn_entry, input, ROB_W, ROB entry that now owns rn_name.
- rd_en, input, NUM_RD, per-port read enable.
- rd_name, input, NUM_RD*REG_W, read register name.
- rd_lock, output, NUM_RD*LOCK_W, lock: {1'b0, entry} when locked, NO_LOCK = {1'b1, {ROB_W{1'b0}}} when free.
- rd_data, output, NUM_RD*DATA_W, register value.
- locked_cnt, output, REG_W+1, registered number of locked registers.

Behaviour:
- State: dat[REG_CNT], loc[REG_CNT], locked_cnt.
- Reset (async, immediate): all dat = 0, all loc = NO_LOCK, locked_cnt = 0. Any in-flight events are discarded.
- Register 0: dat[0] reads 0 and loc[0] reads NO_LOCK. Commits and renames to r0 are ignored.
- Commit, posedge clk, for each i with cm_we[i] and cm_name[i] != 0:
  - dat[name] <= data.
  - If several ports target the same name in one cycle, the highest index wins.
  - loc[name] is cleared to NO_LOCK when loc[name] == {0, cm_entry[i]} for any committing port i, unless overridden by a rename or flush (below).
- Rename, posedge clk, when rn_we, rn_name != 0 and !flush:
  - loc[rn_name] <= {0, rn_entry}.
  - Rename has priority over a same-cycle commit clear of the same register.
- Flush, posedge clk:
  - All loc <= NO_LOCK.
  - Same-cycle commits still write dat.
  - Same-cycle rename is dropped.
- Read, combinational, per port p:
  - !rd_en[p]: lock = NO_LOCK, data = 0.
  - Otherwise, base values are loc[name] and dat[name].
  - Bypass: if a commit port i (highest matching index) has cm_we[i] and cm_name[i] == rd_name[p] != 0, data = cm_data[i].
  - Lock under bypass: NO_LOCK if the base lock equals {0, cm_entry[j]} for any committing port j on that name; otherwise the base lock is unchanged.
  - Same-cycle rename and flush are not visible on the read outputs.
- locked_cnt:
  - Each edge, loads the count of registers whose next-state loc has MSB = 0.
  - Equals 0 after a flush edge.
  - Maximum REG_CNT-1.
- Latency: reads 0 cycles. State updates become visible one edge after the event.

Test Plan:
- Reset mid-run with r3 locked to entry 5 and dat[3]=0xAA -> rd r3 gives lock=NO_LOCK (0x10 for ROB_W=4), data=0, locked_cnt=0, with no clock edge needed.
- Rename r4 to entry 2, then commit r4 data 0x1234 with entry 2 ->
  - Commit cycle read: data 0x1234, lock NO_LOCK.
  - Next cycle: locked_cnt drops from 1 to 0.
- Rename r4 to entry 7, then commit r4 with entry 2 -> dat[4] updates, lock remains {0,7}.
- Same cycle: commit r6 entry 1 (loc[6]={0,1}) and rename r6 to entry 3 -> loc[6]={0,3}, dat[6]=commit data.
- Two commit ports both targeting r9 (port 0 = 0x11, port 1 = 0x22) -> read bypass and stored value are both 0x22.
- Lock r1..r5, then flush together with rename r7 and commit r2=0x55 -> all locks NO_LOCK, r7 unlocked, dat[2]=0x55, locked_cnt=0. A write to r0 leaves it reading 0.
